padctl_regs: RTL
================

Name: padctl_regs

Overview:
Parametrised, register-programmable pad controller for the padring. Holds a per-pad control register (EN, R_EN, PULL_UP, PULL_DOWN) and drives each pad cell's control bits from it. Synchronises and glitch-filters pad input data, then captures rising edges into a W1C status register with a maskable interrupt. Sits between the SoC register bus and the pad-cell instances.

Parameters:
NUM_PADS, 32, number of pads controlled; legal range 1..32.
PAD_CTL_W, 4, control bits per pad: [0] EN (output drive), [1] R_EN (receiver enable), [2] PULL_UP, [3] PULL_DOWN.
RESET_CTL, 4'b0010, reset value of every pad control register (receiver on, driver off, no pulls).
SYNC_STAGES, 2, synchroniser depth on pad input data; minimum 2.
FILT_CNT, 4, consecutive stable synced cycles required before the filtered input changes; legal range 1..15.
ADDR_W, 6, register word-address width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
reg_req  in  1  register access request, single-cycle pulse
reg_we  in  1  1 = write, 0 = read; qualified by reg_req
reg_addr  in  ADDR_W  word address
reg_wdata  in  32  write data
reg_rdata  out  32  read data, valid when reg_ack = 1
reg_ack  out  1  one-cycle acknowledge
pad_din_raw  in  NUM_PADS  asynchronous data from the pad cells' DOUT
pad_ctl  out  NUM_PADS*PAD_CTL_W  flattened control bus; pad i uses bits [i*PAD_CTL_W +: PAD_CTL_W]
pad_in_filt  out  NUM_PADS  filtered input level
pad_irq  out  1  level interrupt

Behaviour:
- Reset (asynchronous, active-high): every control register = RESET_CTL; sync flops, filter counters, pad_in_filt, EDGE, IRQ_EN = 0; reg_ack = 0; reg_rdata = 0; pad_irq = 0.
- Register map (word addresses): 0..NUM_PADS-1 CTL[i] (bits[3:0] RW, other bits read 0); 0x20 IN (RO, pad_in_filt); 0x21 EDGE (W1C); 0x22 IRQ_EN (RW). Bits >= NUM_PADS read 0 and ignore writes. Unmapped addresses read 0, writes are dropped, and ack still pulses.
- Handshake: reg_req in cycle N gives reg_ack = 1 in cycle N+1. A write takes effect on pad_ctl in N+1. Read data is sampled in N and is presented in N+1. A reg_req while reg_ack = 1 is accepted normally, giving back-to-back throughput of 1 access per cycle.
- Pull exclusivity: a CTL write with bits [3:2] = 2'b11 stores PULL_UP = 1, PULL_DOWN = 0. pad_ctl never shows both pull bits set.
- Input path: pad_din_raw passes through SYNC_STAGES flops to give synced[i]. Each pad has a 4-bit counter. When synced != pad_in_filt, the counter increments. The counter resets to 0 on any cycle where they are equal. When the counter reaches FILT_CNT, pad_in_filt toggles and the counter clears. Latency from a stable raw change to pad_in_filt = SYNC_STAGES + FILT_CNT cycles.
- Inputs of pads with R_EN = 0: the filter is held with counter = 0 and pad_in_filt = 0, and no edges are generated. When R_EN is re-enabled, the filter restarts from 0.
- Edge capture: a 0->1 transition of pad_in_filt[i] sets EDGE[i]. If a W1C and a new edge hit the same bit in the same cycle, the edge wins and the bit stays 1.
- pad_irq is registered: |(EDGE & IRQ_EN), updated one cycle after EDGE or IRQ_EN changes.
- Reset asserted mid-access: the access is abandoned, no ack is issued, and all state takes its reset value.

Decomposition:
- Shared package padctl_pkg: control-bit index constants (CTL_EN=0, CTL_REN=1, CTL_PU=2, CTL_PD=3), the register address constants (ADDR_IN, ADDR_EDGE, ADDR_IRQ_EN), and the RESET_CTL default.
- One sub-module, padctl_infilt: a single-pad synchroniser, glitch filter and rising-edge detector (parameters SYNC_STAGES, FILT_CNT), generated NUM_PADS times.
- The top level holds the register file, read mux, pull exclusivity logic and interrupt logic.

Test Plan:
- Reset, then read CTL[0..NUM_PADS-1] -> each returns 0x2; pad_ctl = all pads 4'b0010; pad_irq = 0.
- Write CTL[5] = 0xF -> ack in the next cycle; readback = 0x7; pad_ctl[23:20] = 4'b0111.
- Pad 3 (R_EN = 1) raw goes 0->1 and stays high -> pad_in_filt[3] rises exactly 6 cycles later (SYNC 2 + FILT 4); EDGE[3] = 1. A 3-cycle glitch on pad 4 -> no change and no edge.
- IRQ_EN = 0x8 with EDGE[3] set -> pad_irq = 1. Write EDGE = 0x8 -> pad_irq falls one cycle after EDGE clears. A W1C of EDGE[3] in the same cycle as a new pad-3 rising edge -> EDGE[3] stays 1.
- Write CTL[7] = 0x0 (R_EN = 0) with raw pad 7 held high -> pad_in_filt[7] = 0 and EDGE[7] stays 0. Re-enable with CTL[7] = 0x2 -> pad_in_filt[7] = 1 after 4 cycles.
- Assert rst in the cycle after a reg_req write to CTL[2] -> no ack; CTL[2] = 0x2 after reset. Read of address 0x30 -> ack with rdata = 0.

Source files
------------

// File: rtl/padctl_pkg.sv
// Shared constants for the pad controller: control-bit positions,
// register word addresses and the default per-pad control value.
package padctl_pkg;

  localparam int CTL_EN  = 0;
  localparam int CTL_REN = 1;
  localparam int CTL_PU  = 2;
  localparam int CTL_PD  = 3;

  localparam logic [5:0] ADDR_IN     = 6'h20;
  localparam logic [5:0] ADDR_EDGE   = 6'h21;
  localparam logic [5:0] ADDR_IRQ_EN = 6'h22;

  localparam logic [3:0] CTL_RESET_DEFAULT = 4'b0010;

endpackage

// File: rtl/padctl_infilt.sv
// Single-pad input path: synchroniser, consecutive-cycle glitch filter and
// rising-edge detect of the filtered level.
module padctl_infilt
  import padctl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ren,
  input  logic din_raw,
  output logic filt,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [3:0]             cnt_reg;
  logic [3:0]             cnt_next;
  logic                   filt_reg;
  logic                   filt_next;
  logic                   synced;

  assign synced = sync_reg[SYNC_STAGES-1];
  assign filt   = filt_reg;

  // A disabled receiver holds the filter at zero so re-enable restarts cleanly.
  always_comb begin
    cnt_next  = '0;
    filt_next = filt_reg;
    if (!ren) begin
      filt_next = 1'b0;
    end else if (synced != filt_reg) begin
      if (cnt_reg == 4'(FILT_CNT - 1)) begin
        filt_next = ~filt_reg;
      end else begin
        cnt_next = cnt_reg + 4'd1;
      end
    end
  end

  assign rise = filt_next & ~filt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      cnt_reg  <= '0;
      filt_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din_raw};
      cnt_reg  <= cnt_next;
      filt_reg <= filt_next;
    end
  end

endmodule

// File: rtl/padctl_regs.sv
// Register-programmable pad controller: per-pad control registers, filtered
// input status, W1C rising-edge capture and a maskable level interrupt.
module padctl_regs
  import padctl_pkg::*;
#(
  parameter int                   NUM_PADS    = 32,
  parameter int                   PAD_CTL_W   = 4,
  parameter logic [PAD_CTL_W-1:0] RESET_CTL   = CTL_RESET_DEFAULT,
  parameter int                   SYNC_STAGES = 2,
  parameter int                   FILT_CNT    = 4,
  parameter int                   ADDR_W      = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            reg_req,
  input  logic                            reg_we,
  input  logic [ADDR_W-1:0]               reg_addr,
  input  logic [31:0]                     reg_wdata,
  output logic [31:0]                     reg_rdata,
  output logic                            reg_ack,
  input  logic [NUM_PADS-1:0]             pad_din_raw,
  output logic [NUM_PADS*PAD_CTL_W-1:0]   pad_ctl,
  output logic [NUM_PADS-1:0]             pad_in_filt,
  output logic                            pad_irq
);

  logic                   wr_en;
  logic [PAD_CTL_W-1:0]   ctl_wval;
  logic [NUM_PADS-1:0]    rise;
  logic [NUM_PADS-1:0]    edge_reg;
  logic [NUM_PADS-1:0]    edge_next;
  logic [NUM_PADS-1:0]    edge_clr;
  logic [NUM_PADS-1:0]    irq_en_reg;
  logic [31:0]            rdata_next;

  assign wr_en = reg_req && reg_we;

  // Both pulls requested resolves to pull-up only.
  always_comb begin
    ctl_wval = reg_wdata[PAD_CTL_W-1:0];
    if (ctl_wval[CTL_PU] && ctl_wval[CTL_PD]) begin
      ctl_wval[CTL_PD] = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
    logic [PAD_CTL_W-1:0] ctl_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ctl_reg <= RESET_CTL;
      end else if (wr_en && (reg_addr == ADDR_W'(gi))) begin
        ctl_reg <= ctl_wval;
      end
    end

    assign pad_ctl[gi*PAD_CTL_W +: PAD_CTL_W] = ctl_reg;

    padctl_infilt #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CNT    (FILT_CNT)
    ) u_infilt (
      .clk     (clk),
      .rst     (rst),
      .ren     (ctl_reg[CTL_REN]),
      .din_raw (pad_din_raw[gi]),
      .filt    (pad_in_filt[gi]),
      .rise    (rise[gi])
    );
  end

  // A new edge overrides a simultaneous W1C of the same bit.
  always_comb begin
    edge_clr = '0;
    if (wr_en && (reg_addr == ADDR_W'(ADDR_EDGE))) begin
      edge_clr = reg_wdata[NUM_PADS-1:0];
    end
    edge_next = (edge_reg & ~edge_clr) | rise;
  end

  always_comb begin
    rdata_next = '0;
    if (!reg_we) begin
      for (int i = 0; i < NUM_PADS; i++) begin
        if (reg_addr == ADDR_W'(i)) begin
          rdata_next[PAD_CTL_W-1:0] = pad_ctl[i*PAD_CTL_W +: PAD_CTL_W];
        end
      end
      if (reg_addr == ADDR_W'(ADDR_IN)) begin
        rdata_next[NUM_PADS-1:0] = pad_in_filt;
      end
      if (reg_addr == ADDR_W'(ADDR_EDGE)) begin
        rdata_next[NUM_PADS-1:0] = edge_reg;
      end
      if (reg_addr == ADDR_W'(ADDR_IRQ_EN)) begin
        rdata_next[NUM_PADS-1:0] = irq_en_reg;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_reg   <= '0;
      irq_en_reg <= '0;
      pad_irq    <= 1'b0;
      reg_ack    <= 1'b0;
      reg_rdata  <= '0;
    end else begin
      edge_reg <= edge_next;
      if (wr_en && (reg_addr == ADDR_W'(ADDR_IRQ_EN))) begin
        irq_en_reg <= reg_wdata[NUM_PADS-1:0];
      end
      pad_irq <= |(edge_reg & irq_en_reg);
      reg_ack <= reg_req;
      if (reg_req) begin
        reg_rdata <= rdata_next;
      end
    end
  end

endmodule
